// File: rtl/cpu_pkg.sv
// Shared CPU encodings: write-back select fields, link register and the
// write-back FSM state encoding.
package cpu_pkg;

  typedef enum logic [1:0] {
    RD_RT  = 2'b00,
    RD_RD  = 2'b01,
    RD_R31 = 2'b10,
    RD_ILL = 2'b11
  } regdst_e;

  typedef enum logic [1:0] {
    WS_ALU = 2'b00,
    WS_MEM = 2'b01,
    WS_PC4 = 2'b10,
    WS_ILL = 2'b11
  } wrsrc_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_HOLD  = 2'b10
  } wb_state_e;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/wb_select.sv
// Combinational write-back mux: picks destination register and data, and
// flags reserved select codes (which resolve to zero).
module wb_select
  import cpu_pkg::*;
(
  input  logic [31:0] i_alu,
  input  logic [31:0] i_mem,
  input  logic [31:0] i_pc4,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [1:0]  i_regdst,
  input  logic [1:0]  i_wrsrc,
  output logic [4:0]  o_reg,
  output logic [31:0] o_data,
  output logic        o_illegal
);

  always_comb begin
    o_reg     = '0;
    o_data    = '0;
    o_illegal = 1'b0;
    case (regdst_e'(i_regdst))
      RD_RT:   o_reg = i_rt;
      RD_RD:   o_reg = i_rd;
      RD_R31:  o_reg = REG_RA;
      default: o_illegal = 1'b1;
    endcase
    case (wrsrc_e'(i_wrsrc))
      WS_ALU:  o_data = i_alu;
      WS_MEM:  o_data = i_mem;
      WS_PC4:  o_data = i_pc4;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/choose_wb.sv
// Write-back stage: one-entry capture register with IDLE/WRITE/HOLD flow
// control against register-file stalls, commit counter and sticky select error.
module choose_wb
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      MemData,
  input  logic [31:0]      PC4,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [1:0]       RegDst,
  input  logic [1:0]       WrSrc,
  input  logic             rf_stall,
  output logic             RegWre,
  output logic [4:0]       WriteReg,
  output logic [31:0]      WriteData,
  output logic [CNT_W-1:0] wb_count,
  output logic             sel_err
);

  wb_state_e        r_state;
  logic [31:0]      WD_q;
  logic [4:0]       WR_q;
  logic             r_ill;
  logic [CNT_W-1:0] r_count;
  logic             r_sel_err;

  logic [4:0]  w_reg;
  logic [31:0] w_data;
  logic        w_illegal;
  logic        w_accept;
  logic        w_commit;

  wb_select u_sel (
    .i_alu     (ALUResult),
    .i_mem     (MemData),
    .i_pc4     (PC4),
    .i_rt      (rt),
    .i_rd      (rd),
    .i_regdst  (RegDst),
    .i_wrsrc   (WrSrc),
    .o_reg     (w_reg),
    .o_data    (w_data),
    .o_illegal (w_illegal)
  );

  // A stalled WRITE refuses new work so the held entry is never overwritten.
  assign wb_ready = (r_state == ST_IDLE) || (r_state == ST_WRITE && !rf_stall);
  assign w_accept = wb_valid && wb_ready;
  assign w_commit = (r_state == ST_WRITE) && !rf_stall;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state   <= ST_IDLE;
      WD_q      <= '0;
      WR_q      <= '0;
      r_ill     <= 1'b0;
      r_count   <= '0;
      r_sel_err <= 1'b0;
    end else begin
      if (w_accept) begin
        WD_q      <= w_data;
        WR_q      <= w_reg;
        r_ill     <= w_illegal;
        r_sel_err <= r_sel_err | w_illegal;
      end
      if (w_commit) r_count <= r_count + 1'b1;
      case (r_state)
        ST_IDLE:  if (w_accept) r_state <= ST_WRITE;
        ST_WRITE: begin
          if (rf_stall)      r_state <= ST_HOLD;
          else if (w_accept) r_state <= ST_WRITE;
          else               r_state <= ST_IDLE;
        end
        ST_HOLD:  if (!rf_stall) r_state <= ST_WRITE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Register 0 and illegal entries still commit, but never strobe the file.
  assign RegWre    = w_commit && (WR_q != 5'd0) && !r_ill;
  assign WriteReg  = WR_q;
  assign WriteData = WD_q;
  assign wb_count  = r_count;
  assign sel_err   = r_sel_err;

endmodule
